// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: 1 Hz prescaler, seconds/minutes count, start/stop, lap freeze and clear.
// Latency: minutes/seconds/second_tick update on the edge that ends the internal tick cycle (1 cycle).
// Backpressure: none; command pulses are consumed in the cycle they arrive or dropped.
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   start_stop/lap/clear  single-cycle debounced command pulses
//   minutes, seconds   registered display value (lap capture in LAP_HOLD, else live count)
//   running, lap_active   decoded from the state register
//   overflow           sticky saturation flag, cleared only by clear (or reset)
//   second_tick        one-cycle pulse per counted (non-saturated) second
module stopwatch_controller #(
    parameter int CLOCKS_PER_SECOND = 50000000,
    parameter int MAX_MINUTES       = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       lap_active,
    output logic       overflow,
    output logic       second_tick
);

    localparam int             PW         = $clog2(CLOCKS_PER_SECOND);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLOCKS_PER_SECOND - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [6:0]     MAX_MIN    = 7'(MAX_MINUTES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        LAP_HOLD = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [6:0]    live_min;
    logic [6:0]    live_sec;
    logic [6:0]    lap_min;
    logic [6:0]    lap_sec;

    logic          counting;
    logic          tick;
    logic          saturate;
    logic [6:0]    cnt_min;
    logic [6:0]    cnt_sec;
    logic [PW-1:0] presc_adv;

    // Live count after this cycle's tick (if any). A tick at MAX:59 leaves
    // the count untouched and is reported as a saturation instead.
    always_comb begin
        counting  = (state == RUNNING) || (state == LAP_HOLD);
        tick      = counting && (presc == PRESC_LAST);
        saturate  = tick && (live_min == MAX_MIN) && (live_sec == 7'd59);
        presc_adv = tick ? '0 : presc + PRESC_ONE;
        cnt_min   = live_min;
        cnt_sec   = live_sec;
        if (tick && !saturate) begin
            if (live_sec == 7'd59) begin
                cnt_sec = 7'd0;
                cnt_min = live_min + 7'd1;
            end else begin
                cnt_sec = live_sec + 7'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            presc       <= '0;
            live_min    <= 7'd0;
            live_sec    <= 7'd0;
            lap_min     <= 7'd0;
            lap_sec     <= 7'd0;
            minutes     <= 7'd0;
            seconds     <= 7'd0;
            overflow    <= 1'b0;
            second_tick <= 1'b0;
        end else begin
            // Defaults: count is applied, display follows the live count.
            // A tick is counted before any same-cycle state change.
            second_tick <= tick && !saturate;
            live_min    <= cnt_min;
            live_sec    <= cnt_sec;
            minutes     <= cnt_min;
            seconds     <= cnt_sec;

            case (state)
                IDLE: begin
                    presc <= '0;
                    if (start_stop) begin
                        state <= RUNNING;
                    end
                end

                RUNNING: begin
                    presc <= presc_adv;
                    if (saturate) begin
                        overflow <= 1'b1;
                        state    <= PAUSED;
                    end else if (start_stop) begin
                        state <= PAUSED;
                    end else if (lap) begin
                        state   <= LAP_HOLD;
                        lap_min <= cnt_min;
                        lap_sec <= cnt_sec;
                    end
                end

                LAP_HOLD: begin
                    presc <= presc_adv;
                    if (saturate) begin
                        overflow <= 1'b1;
                        state    <= PAUSED;
                    end else if (start_stop) begin
                        state <= PAUSED;
                    end else if (lap) begin
                        state <= RUNNING;
                    end else begin
                        // Display stays frozen on the capture while counting continues.
                        minutes <= lap_min;
                        seconds <= lap_sec;
                    end
                end

                PAUSED: begin
                    // Prescaler holds so the partial second survives a pause.
                    if (clear) begin
                        state    <= IDLE;
                        presc    <= '0;
                        live_min <= 7'd0;
                        live_sec <= 7'd0;
                        lap_min  <= 7'd0;
                        lap_sec  <= 7'd0;
                        minutes  <= 7'd0;
                        seconds  <= 7'd0;
                        overflow <= 1'b0;
                    end else if (start_stop) begin
                        state <= RUNNING;
                    end
                end

                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase
        end
    end

    assign running    = (state == RUNNING) || (state == LAP_HOLD);
    assign lap_active = (state == LAP_HOLD);

endmodule
